// File: rtl/timebase_pkg.sv
// Shared types and defaults for the step/run timebase that feeds the 4-bit counter.
package timebase_pkg;

  typedef enum logic [1:0] {
    S_STEP_WAIT  = 2'b00,
    S_STEP_FIRE  = 2'b01,
    S_RUN        = 2'b10,
    S_RUN_PAUSED = 2'b11
  } tb_state_t;

  localparam int unsigned DEF_DIV_COUNT = 25_000_000;
  localparam int unsigned DEF_DB_COUNT  = 500_000;

endpackage

// File: rtl/key_conditioner.sv
// Pushbutton front end: 2-flop synchroniser, polarity normalisation, debounce and
// a one-cycle press pulse on the accepted 0->1 transition.
module key_conditioner #(
  parameter int unsigned DB_COUNT    = 500_000,
  parameter bit          KEY_ACT_LOW = 1'b1
) (
  input  logic clk,
  input  logic clr_b,
  input  logic key_noisy,
  output logic key_db,
  output logic press
);

  localparam int unsigned   CW         = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DB_COUNT - 1);
  localparam logic          IDLE_LEVEL = KEY_ACT_LOW;

  logic [1:0]    sync;
  logic          key_sync;
  logic [CW-1:0] cnt;
  logic          key_db_q;

  assign key_sync = sync[1] ^ KEY_ACT_LOW;

  always_ff @(posedge clk) begin
    if (!clr_b) begin
      sync     <= {2{IDLE_LEVEL}};
      cnt      <= '0;
      key_db   <= 1'b0;
      key_db_q <= 1'b0;
      press    <= 1'b0;
    end else begin
      sync     <= {sync[0], key_noisy};
      key_db_q <= key_db;
      press    <= key_db & ~key_db_q;
      // The counter measures how long the synced level has disagreed with the
      // accepted level; any return to agreement restarts it.
      if (key_sync == key_db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        key_db <= key_sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/step_tick_generator.sv
// Count-enable source for the counter stage: single-step on key press or free-run
// from a divider, with pause/resume, all in the CLK50M domain.
module step_tick_generator
  import timebase_pkg::*;
#(
  parameter int unsigned DIV_COUNT   = DEF_DIV_COUNT,
  parameter int unsigned DB_COUNT    = DEF_DB_COUNT,
  parameter bit          KEY_ACT_LOW = 1'b1
) (
  input  logic       CLK50M,
  input  logic       CLRb,
  input  logic       KEY_noisy,
  input  logic       RUN,
  output logic       TICK,
  output logic       PHASE,
  output logic [1:0] STATE,
  output logic       KEY_DB
);

  localparam int unsigned   DW       = $clog2(DIV_COUNT);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_COUNT - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV_COUNT / 2);

  tb_state_t     state;
  logic          run_s1;
  logic          run_s2;
  logic          press;
  logic [DW-1:0] div;
  logic [DW-1:0] div_next;

  key_conditioner #(
    .DB_COUNT   (DB_COUNT),
    .KEY_ACT_LOW(KEY_ACT_LOW)
  ) u_key (
    .clk      (CLK50M),
    .clr_b    (CLRb),
    .key_noisy(KEY_noisy),
    .key_db   (KEY_DB),
    .press    (press)
  );

  assign div_next = (div == DIV_LAST) ? '0 : div + DW'(1);
  assign STATE    = state;

  // The divider advances on every S_RUN cycle, including the one that takes the
  // pause, so run time before and after a pause adds up to exactly one period.
  always_ff @(posedge CLK50M) begin
    if (!CLRb) begin
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
      state  <= S_STEP_WAIT;
      div    <= '0;
      TICK   <= 1'b0;
      PHASE  <= 1'b0;
    end else begin
      run_s1 <= RUN;
      run_s2 <= run_s1;
      TICK   <= 1'b0;
      unique case (state)
        S_STEP_WAIT, S_STEP_FIRE: begin
          div   <= '0;
          PHASE <= 1'b0;
          if (run_s2) begin
            state <= S_RUN;
          end else if (state == S_STEP_WAIT && press) begin
            state <= S_STEP_FIRE;
            TICK  <= 1'b1;
          end else begin
            state <= S_STEP_WAIT;
          end
        end
        S_RUN: begin
          if (!run_s2) begin
            state <= S_STEP_WAIT;
            div   <= '0;
            PHASE <= 1'b0;
          end else begin
            div   <= div_next;
            PHASE <= (div_next >= DIV_HALF);
            TICK  <= (div == DIV_LAST);
            if (press) state <= S_RUN_PAUSED;
          end
        end
        S_RUN_PAUSED: begin
          if (!run_s2) begin
            state <= S_STEP_WAIT;
            div   <= '0;
            PHASE <= 1'b0;
          end else if (press) begin
            state <= S_RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_tick_generator.sv
// Scoreboard bench for step_tick_generator with DIV_COUNT=8, DB_COUNT=4, active-low key.
module tb_step_tick_generator;

  localparam logic [3:0] M_TICK  = 4'b0001;
  localparam logic [3:0] M_PHASE = 4'b0010;
  localparam logic [3:0] M_STATE = 4'b0100;
  localparam logic [3:0] M_KDB   = 4'b1000;
  localparam logic [3:0] M_ALL   = 4'b1111;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [3:0]  mask;
    logic [1:0]  state;
    logic        tick;
    logic        phase;
    logic        kdb;
  } exp_t;

  logic       clk = 1'b0;
  logic       clrb;
  logic       key_noisy;
  logic       run;
  logic       tick;
  logic       phase;
  logic [1:0] state;
  logic       key_db;

  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        sbq[$];

  step_tick_generator #(
    .DIV_COUNT  (8),
    .DB_COUNT   (4),
    .KEY_ACT_LOW(1'b1)
  ) dut (
    .CLK50M   (clk),
    .CLRb     (clrb),
    .KEY_noisy(key_noisy),
    .RUN      (run),
    .TICK     (tick),
    .PHASE    (phase),
    .STATE    (state),
    .KEY_DB   (key_db)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int unsigned at, input string name, input logic [3:0] mask,
                           input logic [1:0] st, input logic tk, input logic ph, input logic kd);
    exp_t e;
    e.cyc = at; e.name = name; e.mask = mask;
    e.state = st; e.tick = tk; e.phase = ph; e.kdb = kd;
    sbq.push_back(e);
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: outputs settle after the posedge, so compare on the following negedge.
  always @(negedge clk) begin
    for (int i = int'(sbq.size()) - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        if (sbq[i].mask[0]) begin
          tests++;
          if (tick !== sbq[i].tick) begin
            fails++;
            $display("FAIL %s.tick @cyc %0d: got %b want %b", sbq[i].name, cyc, tick, sbq[i].tick);
          end
        end
        if (sbq[i].mask[1]) begin
          tests++;
          if (phase !== sbq[i].phase) begin
            fails++;
            $display("FAIL %s.phase @cyc %0d: got %b want %b", sbq[i].name, cyc, phase, sbq[i].phase);
          end
        end
        if (sbq[i].mask[2]) begin
          tests++;
          if (state !== sbq[i].state) begin
            fails++;
            $display("FAIL %s.state @cyc %0d: got %b want %b", sbq[i].name, cyc, state, sbq[i].state);
          end
        end
        if (sbq[i].mask[3]) begin
          tests++;
          if (key_db !== sbq[i].kdb) begin
            fails++;
            $display("FAIL %s.key_db @cyc %0d: got %b want %b", sbq[i].name, cyc, key_db, sbq[i].kdb);
          end
        end
        sbq.delete(i);
      end
    end
  end

  initial begin
    int unsigned e;
    int          r;
    logic [1:0]  st;
    logic        tk;
    logic        ph;

    // Reset with key pressed and RUN high
    clrb = 1'b0; key_noisy = 1'b0; run = 1'b1;
    for (int unsigned c = 1; c <= 3; c++) expect_at(c, "reset", M_ALL, 2'b00, 1'b0, 1'b0, 1'b0);
    wait_until(3);
    clrb = 1'b1; key_noisy = 1'b1;
    expect_at(4, "post_reset", M_ALL, 2'b00, 1'b0, 1'b0, 1'b0);
    expect_at(5, "post_reset", M_ALL, 2'b00, 1'b0, 1'b0, 1'b0);
    expect_at(6, "run_sync", M_ALL, 2'b10, 1'b0, 1'b0, 1'b0);
    expect_at(7, "run_sync", M_ALL, 2'b10, 1'b0, 1'b0, 1'b0);
    wait_until(5);
    run = 1'b0;
    expect_at(8, "to_step", M_ALL, 2'b00, 1'b0, 1'b0, 1'b0);

    // Single step: held 20 cycles
    wait_until(12);
    key_noisy = 1'b0;
    for (int unsigned c = 13; c <= 45; c++)
      expect_at(c, "step", M_ALL, (c == 20) ? 2'b01 : 2'b00, c == 20, 1'b0, (c >= 18 && c < 38));
    wait_until(32);
    key_noisy = 1'b1;

    // Bounce shorter than the debounce window
    wait_until(50);
    for (int unsigned c = 51; c <= 90; c++) expect_at(c, "bounce", M_ALL, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      wait_until(50 + 2 * i);
      key_noisy = (i % 2 == 1);
    end
    wait_until(80);
    key_noisy = 1'b1;

    // Free run entered at E, pause pressed at divider 5 (edge E+38), resumed at E+58
    wait_until(95);
    run = 1'b1;
    e = 98;
    for (int j = 0; j <= 70; j++) begin
      if (j >= 38 && j < 58) begin
        st = 2'b11; tk = 1'b0; ph = 1'b1;
      end else begin
        r  = (j < 38) ? j : j - 20;
        st = 2'b10;
        tk = (r > 0 && r % 8 == 0);
        ph = (r % 8) >= 4;
      end
      expect_at(e + j, (j >= 30) ? "pause" : "run", M_TICK | M_PHASE | M_STATE, st, tk, ph, 1'b0);
    end
    expect_at(133, "pause_kdb", M_KDB, 2'b00, 1'b0, 1'b0, 1'b0);
    expect_at(134, "pause_kdb", M_KDB, 2'b00, 1'b0, 1'b0, 1'b1);
    expect_at(143, "pause_kdb", M_KDB, 2'b00, 1'b0, 1'b0, 1'b1);
    expect_at(144, "pause_kdb", M_KDB, 2'b00, 1'b0, 1'b0, 1'b0);
    expect_at(153, "pause_kdb", M_KDB, 2'b00, 1'b0, 1'b0, 1'b0);
    expect_at(154, "pause_kdb", M_KDB, 2'b00, 1'b0, 1'b0, 1'b1);
    expect_at(163, "pause_kdb", M_KDB, 2'b00, 1'b0, 1'b0, 1'b1);
    expect_at(164, "pause_kdb", M_KDB, 2'b00, 1'b0, 1'b0, 1'b0);
    wait_until(128); key_noisy = 1'b0;
    wait_until(138); key_noisy = 1'b1;
    wait_until(148); key_noisy = 1'b0;
    wait_until(158); key_noisy = 1'b1;
    wait_until(170);
    run = 1'b0;
    expect_at(173, "run_exit", M_ALL, 2'b00, 1'b0, 1'b0, 1'b0);

    // Press lands on the same edge as the synced RUN 0->1
    wait_until(180);
    key_noisy = 1'b0;
    for (int unsigned c = 181; c <= 187; c++) expect_at(c, "corner_pre", M_TICK | M_STATE, 2'b00, 1'b0, 1'b0, 1'b0);
    expect_at(185, "corner_kdb", M_KDB, 2'b00, 1'b0, 1'b0, 1'b0);
    expect_at(186, "corner_kdb", M_KDB, 2'b00, 1'b0, 1'b0, 1'b1);
    wait_until(185);
    run = 1'b1;
    for (int unsigned c = 188; c <= 193; c++)
      expect_at(c, "corner_mode", M_TICK | M_PHASE | M_STATE, 2'b10, 1'b0, c >= 192, 1'b0);
    expect_at(193, "corner_kdb", M_KDB, 2'b00, 1'b0, 1'b0, 1'b1);
    wait_until(192);
    key_noisy = 1'b1;

    // Reset in S_RUN at divider 5
    wait_until(193);
    clrb = 1'b0; run = 1'b0;
    expect_at(194, "mid_reset", M_ALL, 2'b00, 1'b0, 1'b0, 1'b0);
    expect_at(195, "mid_reset", M_ALL, 2'b00, 1'b0, 1'b0, 1'b0);
    wait_until(195);
    clrb = 1'b1;
    for (int unsigned c = 196; c <= 205; c++) expect_at(c, "after_reset", M_ALL, 2'b00, 1'b0, 1'b0, 1'b0);

    wait_until(210);
    foreach (sbq[i]) begin
      tests++;
      fails++;
      $display("FAIL %s.unchecked @cyc %0d: got no sample, want one", sbq[i].name, sbq[i].cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
